// File: rtl/scard_char_rx.sv
// scard_char_rx: ISO 7816-3 T=0 character receiver for the smartcard I/O contact.
// Samples the raw card_io line through a 2-flop synchronizer. Decodes
// start / 8 data / parity framing at a fixed ETU of ETU_CYCLES clk cycles.
// Delivers good bytes through a valid/ack holding register.
// Build option: define SCARD_ERRSIG_EN to drive the T=0 error signal
// (io_drive_low_o) after a bad-parity character. Without it the output is tied 0.
module scard_char_rx #(
  parameter int ETU_CYCLES = 372
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       inverse_i,
  input  logic       io_i,
  input  logic       data_ack_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       parity_err_o,
  output logic       overrun_o,
  output logic       io_drive_low_o,
  output logic       busy_o
);

  localparam int CW = $clog2(ETU_CYCLES);

  // Counter terminal values. Every phase counts from 0 after its entry edge.
  localparam logic [CW-1:0] CNT_HALF  = CW'(ETU_CYCLES / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(ETU_CYCLES - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(ETU_CYCLES - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_GUARD
`ifdef SCARD_ERRSIG_EN
    , S_ERRSIG,
    S_RECOVER
`endif
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic            cnt_clr;
  logic [2:0]      bit_idx;
  logic            shift_en;
  logic            par_en;
  logic            par_ok;
  logic            bit_log;
  logic [7:0]      shreg;
  logic            io_meta;
  logic            io_s;
  logic            io_s_q;
  logic            fall;
`ifdef SCARD_ERRSIG_EN
  logic            par_bad;
`endif

  // Even parity over the logical data byte plus the logical parity bit.
  function automatic logic parity_even(input logic [8:0] v);
    return ~(^v);
  endfunction

  assign fall    = io_s_q & ~io_s;
  assign bit_log = io_s ^ inverse_i;
  assign par_ok  = parity_even({shreg, bit_log});

  // Synchronize the asynchronous card line and keep one cycle of history for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      io_meta <= 1'b1;
      io_s    <= 1'b1;
      io_s_q  <= 1'b1;
    end else begin
      io_meta <= io_i;
      io_s    <= io_meta;
      io_s_q  <= io_s;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and per-phase strobes.
  // The guard is measured from the parity sample cycle. This lets the error
  // signal start exactly 10.5 ETU after the start edge.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (fall) begin
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (cnt == CNT_HALF) begin
          cnt_clr   = 1'b1;
          state_nxt = io_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
            state_nxt = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_clr   = 1'b1;
          par_en    = 1'b1;
          state_nxt = S_GUARD;
        end
      end
      S_GUARD: begin
        if (cnt == CNT_GUARD) begin
          cnt_clr = 1'b1;
`ifdef SCARD_ERRSIG_EN
          state_nxt = par_bad ? S_ERRSIG : S_IDLE;
`else
          state_nxt = S_IDLE;
`endif
        end
      end
`ifdef SCARD_ERRSIG_EN
      S_ERRSIG: begin
        if (cnt == CNT_LAST) begin
          cnt_clr   = 1'b1;
          state_nxt = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (cnt == CNT_LAST) begin
          cnt_clr   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
`endif
      default: begin
        cnt_clr   = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
    // Disabling aborts any character in progress without touching the holding register.
    if (!enable_i) begin
      state_nxt = S_IDLE;
      cnt_clr   = 1'b1;
      shift_en  = 1'b0;
      par_en    = 1'b0;
    end
  end

  // ETU phase counter, restarted at every phase boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Data bit index within the character.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx <= 3'd0;
    end else if (state != S_DATA) begin
      bit_idx <= 3'd0;
    end else if (shift_en) begin
      bit_idx <= bit_idx + 3'd1;
    end
  end

  // Assemble the logical byte. Direct convention is LSB first; inverse is MSB first.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      shreg <= inverse_i ? {shreg[6:0], bit_log} : {bit_log, shreg[7:1]};
    end
  end

`ifdef SCARD_ERRSIG_EN
  // Remember the parity verdict so GUARD can decide whether to signal an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad <= 1'b0;
    end else if (par_en) begin
      par_bad <= ~par_ok;
    end
  end
`endif

  // Holding register and one-cycle flags, updated on the edge after the parity sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o       <= 8'h00;
      data_valid_o <= 1'b0;
      parity_err_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      parity_err_o <= 1'b0;
      overrun_o    <= 1'b0;
      if (par_en && par_ok) begin
        data_o       <= shreg;
        data_valid_o <= 1'b1;
        overrun_o    <= data_valid_o & ~data_ack_i;
      end else if (data_ack_i) begin
        data_valid_o <= 1'b0;
      end
      if (par_en && !par_ok) begin
        parity_err_o <= 1'b1;
      end
    end
  end

  assign busy_o = (state != S_IDLE);

`ifdef SCARD_ERRSIG_EN
  assign io_drive_low_o = (state == S_ERRSIG) & enable_i;
`else
  assign io_drive_low_o = 1'b0;
`endif

endmodule
